// File: rtl/i2c_regbank_ctrl.sv
// i2c_regbank_ctrl: byte register bank behind an I2C slave, with an auto-incrementing
// pointer, ARDY/DRDY stall handshakes and a single-cycle local host port.
module i2c_regbank_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         PTR_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_addr,
    input  logic             i_rw,
    input  logic             i_ardy,
    input  logic [7:0]       i_odata,
    input  logic             i_drdy,
    output logic [7:0]       o_idata,
    output logic             o_acka_rdy,
    output logic             o_ackd_rdy,
    input  logic             i_host_req,
    input  logic             i_host_we,
    input  logic [PTR_W-1:0] i_host_addr,
    input  logic [7:0]       i_host_wdata,
    output logic [7:0]       o_host_rdata,
    output logic             o_host_ack
);

    localparam int               DEPTH   = 1 << PTR_W;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {ST_IDLE, ST_ASVC, ST_DSVC, ST_ACK, ST_HOST} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_ardy_sync;
    logic [2:0]       r_drdy_sync;
    logic             w_aevt;
    logic             w_devt;
    logic             r_apend;
    logic             r_dpend;
    logic             w_aclr;
    logic             w_dclr;
    logic             r_acka_rdy;
    logic             r_ackd_rdy;
    logic             w_acka_nxt;
    logic             w_ackd_nxt;
    logic             w_ack_src;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             r_first;
    logic             r_match;
    logic             r_rw;
    logic             w_addr_match;
    logic [7:0]       r_idata;
    logic [7:0]       r_host_rdata;
    logic [7:0]       r_regs [DEPTH];

    assign w_aevt       = r_ardy_sync[1] & ~r_ardy_sync[2];
    assign w_devt       = r_drdy_sync[1] & ~r_drdy_sync[2];
    assign w_addr_match = (i_addr == DEV_ADDR);
    assign w_ptr_inc    = r_ptr + PTR_ONE;
    assign w_ack_src    = r_acka_rdy ? r_ardy_sync[1] : r_drdy_sync[1];

    // Two synchronizer stages plus a third stage for rising-edge detection on each stall line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ardy_sync <= 3'b000;
            r_drdy_sync <= 3'b000;
        end else begin
            r_ardy_sync <= {r_ardy_sync[1:0], i_ardy};
            r_drdy_sync <= {r_drdy_sync[1:0], i_drdy};
        end
    end

    // Hold each detected event until the FSM takes it from IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_apend <= 1'b0;
            r_dpend <= 1'b0;
        end else begin
            r_apend <= w_aevt | (r_apend & ~w_aclr);
            r_dpend <= w_devt | (r_dpend & ~w_dclr);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state with I2C-over-host priority, pending clears and next handshake levels.
    always_comb begin
        w_state_nxt = r_state;
        w_aclr      = 1'b0;
        w_dclr      = 1'b0;
        w_acka_nxt  = 1'b0;
        w_ackd_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_apend) begin
                    w_state_nxt = ST_ASVC;
                    w_aclr      = 1'b1;
                end else if (r_dpend) begin
                    w_state_nxt = ST_DSVC;
                    w_dclr      = 1'b1;
                end else if (i_host_req) begin
                    w_state_nxt = ST_HOST;
                end
            end
            ST_ASVC: begin
                w_state_nxt = ST_ACK;
                w_acka_nxt  = 1'b1;
            end
            ST_DSVC: begin
                w_state_nxt = ST_ACK;
                w_ackd_nxt  = 1'b1;
            end
            ST_ACK: begin
                if (w_ack_src) begin
                    w_acka_nxt = r_acka_rdy;
                    w_ackd_nxt = r_ackd_rdy;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOST: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake lines are registered so the slave only ever sees clean levels.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acka_rdy <= 1'b0;
            r_ackd_rdy <= 1'b0;
        end else begin
            r_acka_rdy <= w_acka_nxt;
            r_ackd_rdy <= w_ackd_nxt;
        end
    end

    // Register file, pointer, transaction flags and read-data staging.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_first      <= 1'b0;
            r_match      <= 1'b0;
            r_rw         <= 1'b0;
            r_idata      <= 8'h00;
            r_host_rdata <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_HOST) begin
                        r_host_rdata <= r_regs[i_host_addr];
                    end
                end
                ST_ASVC: begin
                    r_match <= w_addr_match;
                    r_rw    <= i_rw;
                    if (!i_rw) begin
                        r_first <= 1'b1;
                    end else begin
                        r_idata <= w_addr_match ? r_regs[r_ptr] : 8'hFF;
                    end
                end
                ST_DSVC: begin
                    if (!r_match) begin
                        r_idata <= 8'hFF;
                    end else if (!r_rw) begin
                        if (r_first) begin
                            r_ptr   <= i_odata[PTR_W-1:0];
                            r_first <= 1'b0;
                        end else begin
                            r_regs[r_ptr] <= i_odata;
                            r_ptr         <= w_ptr_inc;
                        end
                    end else begin
                        r_ptr   <= w_ptr_inc;
                        r_idata <= r_regs[w_ptr_inc];
                    end
                end
                ST_HOST: begin
                    if (i_host_we) begin
                        r_regs[i_host_addr] <= i_host_wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_idata      = r_idata;
    assign o_acka_rdy   = r_acka_rdy;
    assign o_ackd_rdy   = r_ackd_rdy;
    assign o_host_rdata = r_host_rdata;
    assign o_host_ack   = (r_state == ST_HOST);

endmodule

// File: tb/tb_i2c_regbank_ctrl.sv
// tb_i2c_regbank_ctrl: directed scenarios against i2c_regbank_ctrl with hand-computed results.
module tb_i2c_regbank_ctrl;

    localparam int PTR_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [6:0]       i_addr;
    logic             i_rw;
    logic             i_ardy;
    logic [7:0]       i_odata;
    logic             i_drdy;
    logic [7:0]       o_idata;
    logic             o_acka_rdy;
    logic             o_ackd_rdy;
    logic             i_host_req;
    logic             i_host_we;
    logic [PTR_W-1:0] i_host_addr;
    logic [7:0]       i_host_wdata;
    logic [7:0]       o_host_rdata;
    logic             o_host_ack;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 i_clk = ~i_clk;

    i2c_regbank_ctrl #(.DEV_ADDR(7'h42), .PTR_W(PTR_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_addr       (i_addr),
        .i_rw         (i_rw),
        .i_ardy       (i_ardy),
        .i_odata      (i_odata),
        .i_drdy       (i_drdy),
        .o_idata      (o_idata),
        .o_acka_rdy   (o_acka_rdy),
        .o_ackd_rdy   (o_ackd_rdy),
        .i_host_req   (i_host_req),
        .i_host_we    (i_host_we),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata),
        .o_host_rdata (o_host_rdata),
        .o_host_ack   (o_host_ack)
    );

    // One stall phase as the slave would run it: raise the line, wait for the ack, release, wait for the drop.
    task automatic i2c_phase(input bit isData, output int up, output int dn, output logic [7:0] idat);
        logic ack;
        up = -1;
        dn = -1;
        if (isData) i_drdy = 1'b1; else i_ardy = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            ack = isData ? o_ackd_rdy : o_acka_rdy;
            if (ack) begin
                up = n;
                break;
            end
        end
        idat   = o_idata;
        i_ardy = 1'b0;
        i_drdy = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            ack = isData ? o_ackd_rdy : o_acka_rdy;
            if (!ack) begin
                dn = n;
                break;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic i2c_addr(input logic [6:0] a, input logic rw, output int up, output int dn, output logic [7:0] idat);
        i_addr = a;
        i_rw   = rw;
        i2c_phase(1'b0, up, dn, idat);
    endtask

    task automatic i2c_data(input logic [7:0] d, output int up, output int dn, output logic [7:0] idat);
        i_odata = d;
        i2c_phase(1'b1, up, dn, idat);
    endtask

    task automatic host_op(input logic we, input logic [PTR_W-1:0] a, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
        i_host_req   = 1'b1;
        i_host_we    = we;
        i_host_addr  = a;
        i_host_wdata = wd;
        lat = -1;
        rd  = 8'hxx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            if (o_host_ack) begin
                lat = n;
                rd  = o_host_rdata;
                break;
            end
        end
        i_host_req = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        nCompared++; if (o_idata !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_idata: got %h want 00", o_idata); end
        nCompared++; if (o_acka_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_acka: got %b want 0", o_acka_rdy); end
        nCompared++; if (o_ackd_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_ackd: got %b want 0", o_ackd_rdy); end
        nCompared++; if (o_host_rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_hrdata: got %h want 00", o_host_rdata); end
        nCompared++; if (o_host_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_hack: got %b want 0", o_host_ack); end
    endtask

    task automatic test_write_burst();
        int up, dn, lat;
        logic [7:0] d;
        logic [7:0] bytesIn [3];
        bytesIn = '{8'h03, 8'hA5, 8'h5A};
        host_op(1'b1, 4'd5, 8'h3C, lat, d);
        nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL wb_host_lat: got %0d want 1", lat); end
        i2c_addr(7'h42, 1'b0, up, dn, d);
        nCompared++; if (up !== 5) begin nMismatched++; $display("[TB] FAIL wb_a_up: got %0d want 5", up); end
        nCompared++; if (dn !== 3) begin nMismatched++; $display("[TB] FAIL wb_a_dn: got %0d want 3", dn); end
        for (int i = 0; i < 3; i++) begin
            i2c_data(bytesIn[i], up, dn, d);
            nCompared++; if (up !== 5) begin nMismatched++; $display("[TB] FAIL wb_d%0d_up: got %0d want 5", i, up); end
            nCompared++; if (dn !== 3) begin nMismatched++; $display("[TB] FAIL wb_d%0d_dn: got %0d want 3", i, dn); end
        end
        host_op(1'b0, 4'd3, 8'h00, lat, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL wb_reg3: got %h want a5", d); end
        host_op(1'b0, 4'd4, 8'h00, lat, d);
        nCompared++; if (d !== 8'h5A) begin nMismatched++; $display("[TB] FAIL wb_reg4: got %h want 5a", d); end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'h3C) begin nMismatched++; $display("[TB] FAIL wb_ptr5: got %h want 3c", d); end
    endtask

    task automatic test_read_burst();
        int up, dn;
        logic [7:0] d;
        logic [7:0] expData [2];
        expData = '{8'h5A, 8'h3C};
        i2c_addr(7'h42, 1'b0, up, dn, d);
        i2c_data(8'h03, up, dn, d);
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL rb_acka_idata: got %h want a5", d); end
        for (int i = 0; i < 2; i++) begin
            i2c_data(8'h00, up, dn, d);
            nCompared++; if (d !== expData[i]) begin nMismatched++; $display("[TB] FAIL rb_d%0d_idata: got %h want %h", i, d, expData[i]); end
            nCompared++; if (up !== 5) begin nMismatched++; $display("[TB] FAIL rb_d%0d_up: got %0d want 5", i, up); end
        end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'h3C) begin nMismatched++; $display("[TB] FAIL rb_ptr5: got %h want 3c", d); end
    endtask

    task automatic test_wrap();
        int up, dn, lat;
        logic [7:0] d;
        host_op(1'b1, 4'd1, 8'h99, lat, d);
        i2c_addr(7'h42, 1'b0, up, dn, d);
        i2c_data(8'h0F, up, dn, d);
        i2c_data(8'h11, up, dn, d);
        i2c_data(8'h22, up, dn, d);
        host_op(1'b0, 4'd15, 8'h00, lat, d);
        nCompared++; if (d !== 8'h11) begin nMismatched++; $display("[TB] FAIL wr_reg15: got %h want 11", d); end
        host_op(1'b0, 4'd0, 8'h00, lat, d);
        nCompared++; if (d !== 8'h22) begin nMismatched++; $display("[TB] FAIL wr_reg0: got %h want 22", d); end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'h99) begin nMismatched++; $display("[TB] FAIL wr_ptr1: got %h want 99", d); end
        i2c_addr(7'h42, 1'b0, up, dn, d);
        i2c_data(8'hF3, up, dn, d);
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL wr_trunc_ptr3: got %h want a5", d); end
    endtask

    task automatic test_foreign();
        int up, dn, lat;
        logic [7:0] d;
        logic [7:0] bytesIn [2];
        bytesIn = '{8'h00, 8'h77};
        i2c_addr(7'h10, 1'b0, up, dn, d);
        nCompared++; if (up !== 5 || dn !== 3) begin nMismatched++; $display("[TB] FAIL fa_a_ack: got up %0d dn %0d want 5 3", up, dn); end
        for (int i = 0; i < 2; i++) begin
            i2c_data(bytesIn[i], up, dn, d);
            nCompared++; if (up !== 5 || dn !== 3) begin nMismatched++; $display("[TB] FAIL fa_d%0d_ack: got up %0d dn %0d want 5 3", i, up, dn); end
        end
        host_op(1'b0, 4'd0, 8'h00, lat, d);
        nCompared++; if (d !== 8'h22) begin nMismatched++; $display("[TB] FAIL fa_reg0: got %h want 22", d); end
        host_op(1'b0, 4'd3, 8'h00, lat, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL fa_reg3: got %h want a5", d); end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL fa_wptr: got %h want a5", d); end
        i2c_addr(7'h10, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hFF) begin nMismatched++; $display("[TB] FAIL fa_rd_acka: got %h want ff", d); end
        i2c_data(8'h00, up, dn, d);
        nCompared++; if (d !== 8'hFF) begin nMismatched++; $display("[TB] FAIL fa_rd_d0: got %h want ff", d); end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hA5) begin nMismatched++; $display("[TB] FAIL fa_rptr: got %h want a5", d); end
    endtask

    task automatic test_arbitration();
        int up, dn, lat, ackN, hostN;
        bit dropped;
        logic [7:0] d;
        i2c_addr(7'h42, 1'b0, up, dn, d);
        ackN    = -1;
        hostN   = -1;
        dropped = 1'b0;
        i_odata = 8'h02;
        i_drdy  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            if (n == 3) begin
                i_host_req   = 1'b1;
                i_host_we    = 1'b1;
                i_host_addr  = 4'd2;
                i_host_wdata = 8'hC3;
            end
            if (o_ackd_rdy && !dropped) begin
                ackN    = n;
                dropped = 1'b1;
                i_drdy  = 1'b0;
            end
            if (o_host_ack) begin
                hostN      = n;
                i_host_req = 1'b0;
                break;
            end
        end
        i_drdy     = 1'b0;
        i_host_req = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        nCompared++; if (ackN !== 5) begin nMismatched++; $display("[TB] FAIL arb_ackd_cycle: got %0d want 5", ackN); end
        nCompared++; if (hostN !== 9) begin nMismatched++; $display("[TB] FAIL arb_host_cycle: got %0d want 9", hostN); end
        host_op(1'b0, 4'd2, 8'h00, lat, d);
        nCompared++; if (d !== 8'hC3) begin nMismatched++; $display("[TB] FAIL arb_reg2: got %h want c3", d); end
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'hC3) begin nMismatched++; $display("[TB] FAIL arb_i2c_rd: got %h want c3", d); end
    endtask

    task automatic test_reset_mid_ack();
        int up, dn, lat;
        logic [7:0] d;
        host_op(1'b0, 4'd3, 8'h00, lat, d);
        i_addr = 7'h42;
        i_rw   = 1'b1;
        i_ardy = 1'b1;
        up = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            if (o_acka_rdy) begin
                up = n;
                break;
            end
        end
        nCompared++; if (up !== 5) begin nMismatched++; $display("[TB] FAIL mr_a_up: got %0d want 5", up); end
        #2 i_rst = 1'b1;
        #1;
        nCompared++; if (o_acka_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mr_acka: got %b want 0", o_acka_rdy); end
        nCompared++; if (o_idata !== 8'h00) begin nMismatched++; $display("[TB] FAIL mr_idata: got %h want 00", o_idata); end
        nCompared++; if (o_host_rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL mr_hrdata: got %h want 00", o_host_rdata); end
        nCompared++; if (o_ackd_rdy !== 1'b0 || o_host_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL mr_other: got ackd %b hack %b want 0 0", o_ackd_rdy, o_host_ack); end
        i_ardy = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        host_op(1'b0, 4'd3, 8'h00, lat, d);
        nCompared++; if (d !== 8'h00) begin nMismatched++; $display("[TB] FAIL mr_reg3: got %h want 00", d); end
        host_op(1'b1, 4'd0, 8'h5E, lat, d);
        host_op(1'b1, 4'd2, 8'hE2, lat, d);
        i2c_addr(7'h42, 1'b1, up, dn, d);
        nCompared++; if (d !== 8'h5E) begin nMismatched++; $display("[TB] FAIL mr_ptr0: got %h want 5e", d); end
    endtask

    // Watchdog so a stuck design still ends the run with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        i_rst        = 1'b1;
        i_addr       = 7'h00;
        i_rw         = 1'b0;
        i_ardy       = 1'b0;
        i_odata      = 8'h00;
        i_drdy       = 1'b0;
        i_host_req   = 1'b0;
        i_host_we    = 1'b0;
        i_host_addr  = '0;
        i_host_wdata = 8'h00;
        repeat (3) @(negedge i_clk);
        test_reset();
        i_rst = 1'b0;
        @(negedge i_clk);
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_foreign();
        test_arbitration();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
